keypad_entry_ctrl: RTL and testbench

Sequencer that sits downstream of the keypad scanner/decoder. It consumes decoded 4-bit key codes and assembles two decimal operands of up to MAX_DIGITS digits each, with digit entry, backspace, clear and confirm. It then presents both operands to the arithmetic/display datapath through a req/ack handshake. It also drives the value currently being typed for the 7-segment display.

---
 rtl/keypad_entry_ctrl.sv | 127 ++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: assembles two decimal operands from decoded key events
// and hands them to the datapath through a req/ack handshake.
module keypad_entry_ctrl #(
    parameter int          MAX_DIGITS     = 3,
    parameter int          WIDTH          = 10,
    parameter int unsigned TIMEOUT_CYCLES = 270_000_000
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic [3:0]       key_code,
    input  logic             key_valid,
    input  logic             ack,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             req,
    output logic [WIDTH-1:0] disp_value,
    output logic [1:0]       digit_count,
    output logic [1:0]       state_o,
    output logic             key_reject
);
    localparam logic [1:0] ENTER_A  = 2'd0;
    localparam logic [1:0] ENTER_B  = 2'd1;
    localparam logic [1:0] WAIT_ACK = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [1:0]       count;
    logic             key_prev;
    logic [31:0]      tcnt;
    logic             ev, is_digit, is_enter, is_bs, is_clr, timer_run, timeout, full;

    assign ev        = key_valid & ~key_prev;
    assign is_digit  = key_code <= 4'd9;
    assign is_enter  = key_code == 4'hA || key_code == 4'hE;
    assign is_bs     = key_code == 4'hC;
    assign is_clr    = key_code == 4'hD;
    assign timer_run = state == ENTER_B || (state == ENTER_A && count != 2'd0);
    // a key event restarts the timer, so it always beats a same-cycle expiry
    assign timeout   = TIMEOUT_CYCLES != 0 && timer_run && !ev && tcnt == TIMEOUT_CYCLES - 1;
    assign full      = timeout || (ev && is_clr);

    assign disp_value  = state[1] ? operand_b : acc;
    assign digit_count = count;
    assign state_o     = state;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= ENTER_A;
            acc        <= '0;
            count      <= 2'd0;
            operand_a  <= '0;
            operand_b  <= '0;
            req        <= 1'b0;
            key_reject <= 1'b0;
            key_prev   <= 1'b0;
            tcnt       <= '0;
        end else begin
            key_prev   <= key_valid;
            key_reject <= 1'b0;
            if (ev)
                tcnt <= '0;
            else if (timer_run && TIMEOUT_CYCLES != 0)
                tcnt <= tcnt + 32'd1;
            if (full) begin
                state     <= ENTER_A;
                acc       <= '0;
                count     <= 2'd0;
                operand_a <= '0;
                operand_b <= '0;
                req       <= 1'b0;
                tcnt      <= '0;
            end else begin
                case (state)
                    ENTER_A, ENTER_B: if (ev) begin
                        if (is_digit) begin
                            if (count == 2'(MAX_DIGITS))
                                key_reject <= 1'b1;
                            else begin
                                acc   <= (acc << 3) + (acc << 1) + WIDTH'(key_code);
                                count <= count + 2'd1;
                            end
                        end else if (is_bs) begin
                            if (count == 2'd0)
                                key_reject <= 1'b1;
                            else begin
                                acc   <= WIDTH'(acc / 10);
                                count <= count - 2'd1;
                            end
                        end else if (is_enter) begin
                            if (count == 2'd0)
                                key_reject <= 1'b1;
                            else begin
                                acc   <= '0;
                                count <= 2'd0;
                                if (state == ENTER_A) begin
                                    operand_a <= acc;
                                    state     <= ENTER_B;
                                end else begin
                                    operand_b <= acc;
                                    req       <= 1'b1;
                                    state     <= WAIT_ACK;
                                end
                            end
                        end else if (key_code == 4'hB)
                            key_reject <= 1'b1;
                    end
                    WAIT_ACK: begin
                        if (ev)
                            key_reject <= 1'b1;
                        if (ack) begin
                            req   <= 1'b0;
                            state <= DONE;
                        end
                    end
                    default: if (ev && is_digit) begin
                        operand_a <= '0;
                        operand_b <= '0;
                        acc       <= WIDTH'(key_code);
                        count     <= 2'd1;
                        state     <= ENTER_A;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed keypad sequences checked every cycle against
// a digit-queue model of the entry rules, plus hand-computed literal checks.
module tb_keypad_entry_ctrl;
    localparam int TO = 100;
    localparam int MAXD = 3;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [3:0] key_code = 4'hF;
    logic       key_valid = 1'b0;
    logic       ack = 1'b0;
    logic [9:0] operand_a, operand_b, disp_value;
    logic       req, key_reject;
    logic [1:0] digit_count, state_o;

    int n_tests = 0;
    int n_fail = 0;
    logic rej_seen;

    keypad_entry_ctrl #(.MAX_DIGITS(MAXD), .WIDTH(10), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .n_reset(n_reset), .key_code(key_code), .key_valid(key_valid),
        .ack(ack), .operand_a(operand_a), .operand_b(operand_b), .req(req),
        .disp_value(disp_value), .digit_count(digit_count), .state_o(state_o),
        .key_reject(key_reject)
    );

    always #5 clk = ~clk;

    // model: the operand being typed is a queue of decimal digits
    int q[$];
    int m_a = 0, m_b = 0, m_st = 0, m_idle = 0, c;
    bit m_req = 0, m_rej = 0, m_prev = 0, ev, run, to;

    function automatic int qval();
        int v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic model_clear();
        q.delete();
        m_a = 0; m_b = 0; m_req = 0; m_st = 0; m_idle = 0;
    endtask

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            model_clear();
            m_rej = 0; m_prev = 0;
        end else begin
            ev = key_valid && !m_prev;
            m_prev = key_valid;
            c = int'(key_code);
            m_rej = 0;
            run = m_st == 1 || (m_st == 0 && q.size() > 0);
            to = 0;
            if (ev) m_idle = 0;
            else if (run) begin
                m_idle++;
                to = m_idle == TO;
            end
            if (to || (ev && c == 13)) model_clear();
            else if (m_st < 2 && ev) begin
                if (c <= 9) begin
                    if (q.size() == MAXD) m_rej = 1; else q.push_back(c);
                end else if (c == 12) begin
                    if (q.size() == 0) m_rej = 1; else void'(q.pop_back());
                end else if (c == 10 || c == 14) begin
                    if (q.size() == 0) m_rej = 1;
                    else begin
                        if (m_st == 0) begin m_a = qval(); m_st = 1; end
                        else begin m_b = qval(); m_req = 1; m_st = 2; end
                        q.delete();
                    end
                end else if (c == 11) m_rej = 1;
            end else if (m_st == 2) begin
                if (ev) m_rej = 1;
                if (ack) begin m_req = 0; m_st = 3; end
            end else if (m_st == 3 && ev && c <= 9) begin
                model_clear();
                q.push_back(c);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("operand_a", int'(operand_a), m_a);
        check("operand_b", int'(operand_b), m_b);
        check("req", int'(req), int'(m_req));
        check("disp_value", int'(disp_value), m_st < 2 ? qval() : m_b);
        check("digit_count", int'(digit_count), q.size());
        check("state_o", int'(state_o), m_st);
        check("key_reject", int'(key_reject), int'(m_rej));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_code = k;
        key_valid = 1'b1;
        tick();
        rej_seen = key_reject;
        key_valid = 1'b0;
        key_code = 4'hF;
        tick();
    endtask

    initial begin
        repeat (2) tick();
        n_reset = 1'b1;
        tick();
        check("reset_state", int'(state_o), 0);
        check("reset_disp", int'(disp_value), 0);
        check("reset_req", int'(req), 0);

        press(4'h1); press(4'h2); press(4'h3); press(4'hA);
        press(4'h4); press(4'h5); press(4'hE);
        check("lit_op_a_123", int'(operand_a), 123);
        check("lit_op_b_45", int'(operand_b), 45);
        check("lit_req_high", int'(req), 1);
        check("lit_wait_ack", int'(state_o), 2);
        ack = 1'b1; tick(); ack = 1'b0;
        check("lit_req_low", int'(req), 0);
        check("lit_done", int'(state_o), 3);
        check("lit_done_disp", int'(disp_value), 45);
        press(4'hC);
        check("lit_done_ignore", int'(state_o), 3);

        press(4'h9); press(4'h9); press(4'h9);
        check("lit_3rd9_norej", int'(rej_seen), 0);
        press(4'h9);
        check("lit_4th9_rej", int'(rej_seen), 1);
        check("lit_disp_999", int'(disp_value), 999);
        check("lit_count_3", int'(digit_count), 3);

        press(4'hD);
        press(4'h4); press(4'h7); press(4'hC); press(4'h2);
        check("lit_disp_42", int'(disp_value), 42);
        check("lit_count_2", int'(digit_count), 2);
        ack = 1'b1; tick(); ack = 1'b0;
        press(4'hC); press(4'hC);
        check("lit_bs_norej", int'(rej_seen), 0);
        press(4'hC);
        check("lit_bs_rej", int'(rej_seen), 1);
        check("lit_disp_0", int'(disp_value), 0);
        press(4'hA);
        check("lit_enter_empty_rej", int'(rej_seen), 1);
        press(4'hB);
        check("lit_keyB_rej", int'(rej_seen), 1);
        press(4'hF);
        check("lit_keyF_silent", int'(rej_seen), 0);

        press(4'h1); press(4'hA); press(4'h2); press(4'hE);
        check("lit_wait_ack2", int'(state_o), 2);
        press(4'h3);
        check("lit_wait_key_rej", int'(rej_seen), 1);
        key_code = 4'hD; key_valid = 1'b1; ack = 1'b1;
        tick();
        key_valid = 1'b0; ack = 1'b0; key_code = 4'hF;
        tick();
        check("lit_clr_req", int'(req), 0);
        check("lit_clr_state", int'(state_o), 0);
        check("lit_clr_op_a", int'(operand_a), 0);
        check("lit_clr_op_b", int'(operand_b), 0);

        press(4'h5);
        repeat (TO - 2) tick();
        check("lit_before_timeout", int'(disp_value), 5);
        tick();
        check("lit_timeout_disp", int'(disp_value), 0);
        check("lit_timeout_count", int'(digit_count), 0);
        check("lit_timeout_state", int'(state_o), 0);

        key_code = 4'h7; key_valid = 1'b1;
        repeat (50) tick();
        key_valid = 1'b0; key_code = 4'hF;
        tick();
        check("lit_hold_disp", int'(disp_value), 7);
        check("lit_hold_count", int'(digit_count), 1);

        press(4'h3);
        #3 n_reset = 1'b0;
        #1;
        check("lit_rst_disp", int'(disp_value), 0);
        check("lit_rst_count", int'(digit_count), 0);
        check("lit_rst_state", int'(state_o), 0);
        check("lit_rst_req", int'(req), 0);
        repeat (2) tick();
        n_reset = 1'b1;
        press(4'h8);
        check("lit_after_rst", int'(disp_value), 8);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
